// File: rtl/decode_inst_queue_pkg.sv
// ----------------------------------------------------------------------------
// decode_inst_queue_pkg
// Shared definitions for the decode instruction queue: functional unit codes,
// register access pattern encodings, default field widths and the width of
// one packed instruction record as stored in the queue.
// ----------------------------------------------------------------------------
package decode_inst_queue_pkg;

    // Functional unit codes carried in funcUnitType (code 5 is unassigned)
    typedef enum logic [2:0] {
        FU_FX     = 3'd0,
        FU_FP     = 3'd1,
        FU_VX     = 3'd2,
        FU_CR     = 3'd3,
        FU_LS     = 3'd4,
        FU_BRANCH = 3'd6
    } funcUnit_e;

    // Per-operand register access pattern encodings
    localparam logic [1:0] regRead  = 2'b10;
    localparam logic [1:0] regWrite = 2'b01;

    // Default queue geometry
    localparam int defDepth            = 8;
    localparam int defAlmostFullMargin = 2;

    // Default record field widths
    localparam int defAddressWidth            = 64;
    localparam int defOpcodeSize              = 12;
    localparam int defFuncUnitCodeSize        = 3;
    localparam int defInstructionCounterWidth = 64;
    localparam int defInstMinIdWidth          = 7;
    localparam int defPidSize                 = 20;
    localparam int defTidSize                 = 16;
    localparam int defRegAccessPatternSize    = 2;
    localparam int defBodyWidth               = 84;

    // One stored record: opcode, address, unit, majID, minID, is64Bit,
    // pid, tid, four rw patterns, four is-reg flags and the operand body
    localparam int defRecordWidth = defOpcodeSize + defAddressWidth
                                  + defFuncUnitCodeSize + defInstructionCounterWidth
                                  + defInstMinIdWidth + 1 + defPidSize + defTidSize
                                  + 4 * defRegAccessPatternSize + 4 + defBodyWidth;

endpackage

// File: rtl/decode_inst_queue_queue_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// queue_ptr_ctrl
// Pointer and occupancy control for the decode instruction queue. Owns the
// head/tail pointers and the occupancy count, decides which pushes and pops
// are accepted, and produces the registered almost-full stall and the sticky
// overflow flag.
//
// Optional feature macro: DECODE_QUEUE_FLUSH_EN adds flush_i, which empties
// the queue and takes priority over any push or pop in the same cycle.
//
// Ports:
//   clock_i, reset_i  clock, asynchronous active-high reset
//   flush_i           (DECODE_QUEUE_FLUSH_EN only) empty the queue
//   enable_i          upstream presents a record this cycle
//   ready_i           dispatch accepts the head this cycle
//   wrEn_o            write the incoming record at wrPtr_o
//   wrPtr_o, rdPtr_o  tail and head pointers
//   count_o           occupancy
//   valid_o           head entry holds a record
//   stall_o           registered almost-full back-pressure
//   overflow_o        sticky: a push was dropped
// ----------------------------------------------------------------------------
module queue_ptr_ctrl
    import decode_inst_queue_pkg::*;
#(
    parameter int depth            = defDepth,
    parameter int almostFullMargin = defAlmostFullMargin
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
`ifdef DECODE_QUEUE_FLUSH_EN
    input  logic                       flush_i,
`endif
    input  logic                       enable_i,
    input  logic                       ready_i,
    output logic                       wrEn_o,
    output logic [$clog2(depth)-1:0]   wrPtr_o,
    output logic [$clog2(depth)-1:0]   rdPtr_o,
    output logic [$clog2(depth):0]     count_o,
    output logic                       valid_o,
    output logic                       stall_o,
    output logic                       overflow_o
);

    localparam int ptrWidth = $clog2(depth);
    localparam int cntWidth = ptrWidth + 1;

    logic [ptrWidth-1:0] head_q, head_d;
    logic [ptrWidth-1:0] tail_q, tail_d;
    logic [cntWidth-1:0] count_q, count_d;
    logic                stall_q, stall_d;
    logic                overflow_q, overflow_d;
    logic                isFull, pop, push, drop, flush;

`ifdef DECODE_QUEUE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Accept decisions and next-state. A full queue still takes a push when
    // the head leaves in the same cycle. Flush wins over everything except
    // the sticky overflow flag, which only reset clears.
    always_comb begin
        isFull     = (count_q == cntWidth'(depth));
        pop        = (count_q != '0) && ready_i;
        push       = enable_i && (!isFull || pop);
        drop       = enable_i && isFull && !pop;

        head_d     = pop  ? head_q + ptrWidth'(1) : head_q;
        tail_d     = push ? tail_q + ptrWidth'(1) : tail_q;
        count_d    = count_q + cntWidth'(push) - cntWidth'(pop);
        overflow_d = overflow_q | (drop && !flush);
        wrEn_o     = push && !flush;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        stall_d = !flush
                  && ((cntWidth'(depth) - count_d) <= cntWidth'(almostFullMargin));
    end

    // State registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    assign wrPtr_o    = tail_q;
    assign rdPtr_o    = head_q;
    assign count_o    = count_q;
    assign valid_o    = (count_q != '0);
    assign stall_o    = stall_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/decode_inst_queue.sv
// ----------------------------------------------------------------------------
// decode_inst_queue
// Circular instruction buffer between the decode mux and rename/dispatch.
// One decoded record is captured per cycle when enable_i is high; the oldest
// record is presented show-ahead with a valid/ready handshake. A registered
// almost-full stall leaves room for instructions still in flight upstream.
//
// Optional feature macro: DECODE_QUEUE_FLUSH_EN adds flush_i (branch
// mispredict) which empties the queue; overflow_o survives a flush.
//
// Ports:
//   clock_i, reset_i     clock, asynchronous active-high reset
//   flush_i              (DECODE_QUEUE_FLUSH_EN only) empty the queue
//   enable_i             record valid from the decode mux
//   *_i record fields    opcode, address, funcUnitType, majID, minID,
//                        is64Bit, pid, tid, opRw, opIsReg, body
//   stall_o              almost-full back-pressure, registered
//   valid_o / ready_i    head handshake with dispatch
//   *_o record fields    head record, all zero while valid_o is low
//   count_o              occupancy
//   overflow_o           sticky: a push was dropped
// ----------------------------------------------------------------------------
module decode_inst_queue
    import decode_inst_queue_pkg::*;
#(
    parameter int depth                   = defDepth,
    parameter int almostFullMargin        = defAlmostFullMargin,
    parameter int addressWidth            = defAddressWidth,
    parameter int opcodeSize              = defOpcodeSize,
    parameter int funcUnitCodeSize        = defFuncUnitCodeSize,
    parameter int instructionCounterWidth = defInstructionCounterWidth,
    parameter int instMinIdWidth          = defInstMinIdWidth,
    parameter int PidSize                 = defPidSize,
    parameter int TidSize                 = defTidSize,
    parameter int regAccessPatternSize    = defRegAccessPatternSize,
    parameter int bodyWidth               = defBodyWidth
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
`ifdef DECODE_QUEUE_FLUSH_EN
    input  logic                                flush_i,
`endif
    input  logic                                enable_i,
    input  logic [opcodeSize-1:0]               opcode_i,
    input  logic [addressWidth-1:0]             address_i,
    input  logic [funcUnitCodeSize-1:0]         funcUnitType_i,
    input  logic [instructionCounterWidth-1:0]  majID_i,
    input  logic [instMinIdWidth-1:0]           minID_i,
    input  logic                                is64Bit_i,
    input  logic [PidSize-1:0]                  pid_i,
    input  logic [TidSize-1:0]                  tid_i,
    input  logic [4*regAccessPatternSize-1:0]   opRw_i,
    input  logic [3:0]                          opIsReg_i,
    input  logic [bodyWidth-1:0]                body_i,
    output logic                                stall_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [opcodeSize-1:0]               opcode_o,
    output logic [addressWidth-1:0]             address_o,
    output logic [funcUnitCodeSize-1:0]         funcUnitType_o,
    output logic [instructionCounterWidth-1:0]  majID_o,
    output logic [instMinIdWidth-1:0]           minID_o,
    output logic                                is64Bit_o,
    output logic [PidSize-1:0]                  pid_o,
    output logic [TidSize-1:0]                  tid_o,
    output logic [4*regAccessPatternSize-1:0]   opRw_o,
    output logic [3:0]                          opIsReg_o,
    output logic [bodyWidth-1:0]                body_o,
    output logic [$clog2(depth):0]              count_o,
    output logic                                overflow_o
);

    localparam int ptrWidth = $clog2(depth);
    localparam int recWidth = opcodeSize + addressWidth + funcUnitCodeSize
                            + instructionCounterWidth + instMinIdWidth + 1
                            + PidSize + TidSize + 4 * regAccessPatternSize
                            + 4 + bodyWidth;

    logic [recWidth-1:0] mem_q [depth];
    logic [recWidth-1:0] wrRec;
    logic [recWidth-1:0] headRec;
    logic                wrEn;
    logic [ptrWidth-1:0] wrPtr;
    logic [ptrWidth-1:0] rdPtr;

    queue_ptr_ctrl #(
        .depth            (depth),
        .almostFullMargin (almostFullMargin)
    ) u_ptrCtrl (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
`ifdef DECODE_QUEUE_FLUSH_EN
        .flush_i    (flush_i),
`endif
        .enable_i   (enable_i),
        .ready_i    (ready_i),
        .wrEn_o     (wrEn),
        .wrPtr_o    (wrPtr),
        .rdPtr_o    (rdPtr),
        .count_o    (count_o),
        .valid_o    (valid_o),
        .stall_o    (stall_o),
        .overflow_o (overflow_o)
    );

    assign wrRec = {opcode_i, address_i, funcUnitType_i, majID_i, minID_i,
                    is64Bit_i, pid_i, tid_i, opRw_i, opIsReg_i, body_i};

    // Record storage: plain registers without reset, since the contents are
    // only observable while the occupancy says the entry is live
    always_ff @(posedge clock_i) begin
        if (wrEn) begin
            mem_q[wrPtr] <= wrRec;
        end
    end

    // Show-ahead read straight from storage; no bypass of the incoming
    // record, so a fresh push is visible one cycle after it is written
    assign headRec = valid_o ? mem_q[rdPtr] : '0;

    assign {opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
            is64Bit_o, pid_o, tid_o, opRw_o, opIsReg_o, body_o} = headRec;

endmodule

// File: tb/tb_decode_inst_queue.sv
// ----------------------------------------------------------------------------
// tb_decode_inst_queue
// Self-checking bench for decode_inst_queue with default parameters. Expected
// records are queued when a push is issued and compared by a monitor each
// time the DUT hands its head record to dispatch.
// ----------------------------------------------------------------------------
module tb_decode_inst_queue;

    typedef struct packed {
        logic [11:0] opcode;
        logic [63:0] address;
        logic [2:0]  funcUnit;
        logic [63:0] majID;
        logic [6:0]  minID;
        logic        is64;
        logic [19:0] pid;
        logic [15:0] tid;
        logic [7:0]  opRw;
        logic [3:0]  opIsReg;
        logic [83:0] body;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [11:0] opcode_i = '0;
    logic [63:0] address_i = '0;
    logic [2:0]  funcUnitType_i = '0;
    logic [63:0] majID_i = '0;
    logic [6:0]  minID_i = '0;
    logic        is64Bit_i = 1'b0;
    logic [19:0] pid_i = '0;
    logic [15:0] tid_i = '0;
    logic [7:0]  opRw_i = '0;
    logic [3:0]  opIsReg_i = '0;
    logic [83:0] body_i = '0;
`ifdef DECODE_QUEUE_FLUSH_EN
    logic        flush_i = 1'b0;
`endif

    logic        stall_o, valid_o, overflow_o, is64Bit_o;
    logic [11:0] opcode_o;
    logic [63:0] address_o, majID_o;
    logic [2:0]  funcUnitType_o;
    logic [6:0]  minID_o;
    logic [19:0] pid_o;
    logic [15:0] tid_o;
    logic [7:0]  opRw_o;
    logic [3:0]  opIsReg_o;
    logic [83:0] body_o;
    logic [3:0]  count_o;

    int   checks = 0;
    int   errors = 0;
    rec_t expQ[$];

    decode_inst_queue dut (
        .clock_i        (clock),
        .reset_i        (reset_i),
`ifdef DECODE_QUEUE_FLUSH_EN
        .flush_i        (flush_i),
`endif
        .enable_i       (enable_i),
        .opcode_i       (opcode_i),
        .address_i      (address_i),
        .funcUnitType_i (funcUnitType_i),
        .majID_i        (majID_i),
        .minID_i        (minID_i),
        .is64Bit_i      (is64Bit_i),
        .pid_i          (pid_i),
        .tid_i          (tid_i),
        .opRw_i         (opRw_i),
        .opIsReg_i      (opIsReg_i),
        .body_i         (body_i),
        .stall_o        (stall_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .opcode_o       (opcode_o),
        .address_o      (address_o),
        .funcUnitType_o (funcUnitType_o),
        .majID_o        (majID_o),
        .minID_o        (minID_o),
        .is64Bit_o      (is64Bit_o),
        .pid_o          (pid_o),
        .tid_o          (tid_o),
        .opRw_o         (opRw_o),
        .opIsReg_o      (opIsReg_o),
        .body_o         (body_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clock = ~clock;

    // Deterministic directed record for sequence number n
    function automatic rec_t makeRec(input int unsigned n);
        rec_t r;
        r.opcode   = 12'h100 + 12'(n);
        r.address  = 64'hFFFF_0000_0000_0000 + 64'(n) * 64'd4;
        r.funcUnit = 3'(n);
        r.majID    = 64'(n);
        r.minID    = 7'(n + 3);
        r.is64     = n[0];
        r.pid      = 20'hA0000 + 20'(n);
        r.tid      = 16'h5000 + 16'(n);
        r.opRw     = 8'(n * 17);
        r.opIsReg  = 4'(n);
        r.body     = {20'hABCDE, 64'h0123_4567_89AB_0000 + 64'(n)};
        return r;
    endfunction

    function automatic rec_t dutRec();
        return {opcode_o, address_o, funcUnitType_o, majID_o, minID_o,
                is64Bit_o, pid_o, tid_o, opRw_o, opIsReg_o, body_o};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkRecord(input string name, input rec_t act, input rec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus; accepted pushes go to the scoreboard
    task automatic applyStimulus(input logic en, input rec_t r, input logic rdy,
                                 input bit accept);
        enable_i       = en;
        ready_i        = rdy;
        opcode_i       = r.opcode;
        address_i      = r.address;
        funcUnitType_i = r.funcUnit;
        majID_i        = r.majID;
        minID_i        = r.minID;
        is64Bit_i      = r.is64;
        pid_i          = r.pid;
        tid_i          = r.tid;
        opRw_i         = r.opRw;
        opIsReg_i      = r.opIsReg;
        body_i         = r.body;
        if (en && accept) expQ.push_back(r);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic pulseReset();
        #1 reset_i = 1'b1;
        #1 reset_i = 1'b0;
        expQ.delete();
    endtask

    // Scoreboard monitor: every accepted pop must match the oldest expected
    always @(negedge clock) begin
        if (!reset_i && valid_o && ready_i) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL popUnexpected: got majID %0d expected no record", majID_o);
            end else begin
                checkRecord("popRecord", dutRec(), expQ.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rec_t r;

        // Reset state
        tick();
        checkOutput("resetCount", 64'(count_o), 64'd0);
        checkOutput("resetValid", 64'(valid_o), 64'd0);
        checkOutput("resetStall", 64'(stall_o), 64'd0);
        checkOutput("resetOverflow", 64'(overflow_o), 64'd0);
        tick();
        reset_i = 1'b0;

        // Reset in the middle of operation with three entries queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, makeRec(100 + i), 1'b0, 1'b1);
            tick();
        end
        idle();
        tick();
        checkOutput("preResetCount", 64'(count_o), 64'd3);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("asyncResetCount", 64'(count_o), 64'd0);
        checkOutput("asyncResetValid", 64'(valid_o), 64'd0);
        checkOutput("asyncResetStall", 64'(stall_o), 64'd0);
        checkOutput("asyncResetOverflow", 64'(overflow_o), 64'd0);
        expQ.delete();
        tick();
        reset_i = 1'b0;

        // Single record held for five cycles, then accepted
        r = makeRec(40);
        r.opcode   = 12'd4;
        r.funcUnit = 3'd1;
        r.opRw     = 8'b01_10_00_10;
        r.opIsReg  = 4'b1101;
        r.body     = 84'd1;
        applyStimulus(1'b1, r, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("singleValid", 64'(valid_o), 64'd1);
        checkOutput("singleOpcode", 64'(opcode_o), 64'd4);
        checkOutput("singleOpRw", 64'(opRw_o), 64'h62);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkRecord("singleHold", dutRec(), r);
        end
        ready_i = 1'b1;
        tick();
        idle();
        checkOutput("singlePoppedValid", 64'(valid_o), 64'd0);
        checkRecord("idleZero", dutRec(), '0);

        // Fill to eight, stall from the sixth entry, ninth push dropped
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, makeRec(i), 1'b0, 1'b1);
            tick();
            checkOutput("fillCount", 64'(count_o), 64'(i + 1));
            checkOutput("fillStall", 64'(stall_o), (i + 1 >= 6) ? 64'd1 : 64'd0);
        end
        applyStimulus(1'b1, makeRec(8), 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("dropOverflow", 64'(overflow_o), 64'd1);
        checkOutput("dropCount", 64'(count_o), 64'd8);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        idle();
        checkOutput("drainCount", 64'(count_o), 64'd0);
        checkOutput("drainStall", 64'(stall_o), 64'd0);
        checkOutput("overflowSticky", 64'(overflow_o), 64'd1);

        // Full queue with simultaneous push and pop
        pulseReset();
        tick();
        checkOutput("overflowCleared", 64'(overflow_o), 64'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, makeRec(i), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, makeRec(8), 1'b1, 1'b1);
        tick();
        idle();
        checkOutput("fullSimOverflow", 64'(overflow_o), 64'd0);
        checkOutput("fullSimCount", 64'(count_o), 64'd8);
        checkOutput("fullSimHead", majID_o, 64'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        idle();
        checkOutput("fullSimDrain", 64'(count_o), 64'd0);

        // Wrap-around with continuous push and pop
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, makeRec(200 + i), 1'b1, 1'b1);
            tick();
            checkOutput("wrapCount", 64'(count_o), 64'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        idle();
        checkOutput("wrapEmpty", 64'(count_o), 64'd0);

`ifdef DECODE_QUEUE_FLUSH_EN
        // Flush with a concurrent push empties the queue
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, makeRec(300 + i), 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, makeRec(305), 1'b0, 1'b0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle();
        expQ.delete();
        checkOutput("flushCount", 64'(count_o), 64'd0);
        checkOutput("flushValid", 64'(valid_o), 64'd0);
        checkOutput("flushStall", 64'(stall_o), 64'd0);
        applyStimulus(1'b1, makeRec(310), 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("postFlushValid", 64'(valid_o), 64'd1);
        checkOutput("postFlushHead", majID_o, 64'd310);
        ready_i = 1'b1;
        tick();
        idle();
`endif

        tick();
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Instruction buffer that sits directly downstream of the decode mux and upstream of rename/dispatch.
- Captures one decoded instruction record per cycle when the mux asserts enable.
- Holds records in a circular FIFO and presents the oldest to dispatch with a valid/ready handshake.
- Raises a registered almost-full stall back to fetch/decode, absorbing instructions still in flight in the pipeline.

Parameters:
- depth, 8, number of entries; power of 2, minimum 4
- almostFullMargin, 2, stall_o asserts when free entries <= this value
- addressWidth, 64, instruction address width
- opcodeSize, 12, decoded opcode width
- funcUnitCodeSize, 3, functional unit code width
- instructionCounterWidth, 64, major ID width
- instMinIdWidth, 7, minor ID width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- regAccessPatternSize, 2, per-operand read/write pattern width
- bodyWidth, 84, operand body width (4 regs + 64-bit imm)

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- enable_i  in  1  record valid from decode mux
- opcode_i  in  opcodeSize  decoded opcode
- address_i  in  addressWidth  instruction address
- funcUnitType_i  in  funcUnitCodeSize  target functional unit
- majID_i  in  instructionCounterWidth  major ID
- minID_i  in  instMinIdWidth  minor ID
- is64Bit_i  in  1  64-bit mode
- pid_i  in  PidSize  process ID
- tid_i  in  TidSize  thread ID
- opRw_i  in  4*regAccessPatternSize  op1..op4 rw patterns, op1 in MSBs
- opIsReg_i  in  4  op1..op4 is-register flags, op1 at bit 0
- body_i  in  bodyWidth  operand body
- stall_o  out  1  almost-full back-pressure to upstream, registered
- valid_o  out  1  head record valid
- ready_i  in  1  dispatch accepts head this cycle
- opcode_o … body_o  out  same widths as inputs  head record fields
- count_o  out  log2(depth)+1  occupancy
- overflow_o  out  1  sticky: a push was dropped

Behaviour:
- Reset: head/tail pointers = 0, count_o = 0, valid_o = 0, stall_o = 0, overflow_o = 0. All record outputs are driven 0 while valid_o = 0.
- Push: enable_i = 1 at a rising edge with count < depth, or with count == depth and pop in the same cycle. The record is written at tail and tail increments modulo depth.
- Dropped push: enable_i = 1 with count == depth and no pop. The record is discarded and overflow_o is set; it clears only on reset.
- Pop: valid_o && ready_i at a rising edge. Head increments modulo depth.
- ready_i while valid_o = 0 is ignored.
- Show-ahead: outputs present mem[head] combinationally from storage. valid_o = (count != 0).
- Latency: a record pushed at edge N is visible with valid_o = 1 after edge N. Write-through bypass is not allowed, so latency is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance. When count == 1, the next head is the newly written entry.
- count_o next = count + push - pop.
- stall_o next = ((depth - count_next) <= almostFullMargin).
- Pointers are log2(depth) bits and wrap naturally. Full/empty is resolved by count, not by pointer compare.
- Head record is held stable while valid_o && !ready_i.

Optional Feature:
- DECODE_QUEUE_FLUSH_EN defined: adds input flush_i (1 bit), used for branch mispredict.
  - flush_i at an edge sets head = tail = 0, count = 0, valid_o = 0, stall_o = 0.
  - Flush has priority over any push or pop in the same cycle.
  - overflow_o is preserved across flush.
- Undefined: no flush_i port; the queue empties only by popping.

Decomposition:
- Shared header/package holds:
  - functional unit IDs (FX=0, FP=1, VX=2, CR=3, LS=4, Branch=6)
  - regRead = 2'b10, regWrite = 2'b01
  - default field widths
  - the packed record width constant = sum of all field widths
- The queue stores one concatenated record word per entry.
- One natural sub-module: queue_ptr_ctrl.
  - Holds head/tail/count and computes push/pop accept, stall, overflow, and flush logic.
  - The storage array stays in decode_inst_queue.

Test Plan:
- Reset mid-operation: 3 entries queued, assert reset_i asynchronously between edges -> count_o = 0, valid_o = 0, stall_o = 0, overflow_o = 0 immediately.
- Single record: push opcode = 4, funcUnitType = 1, opRw = 8'b01_10_00_10, opIsReg = 4'b1101, body LSB = 1, ready_i = 0 -> valid_o = 1 one cycle later with identical fields. Head holds for 5 cycles until ready_i = 1, then valid_o = 0.
- Fill: push 8 records (majID 0..7) with ready_i = 0 -> stall_o rises after the 6th push (count = 6). A 9th push sets overflow_o = 1 and count_o stays 8. Popping all yields majID 0..7 in order.
- Full simultaneous: count = 8, enable_i = 1, ready_i = 1 -> push accepted, overflow_o stays 0, count_o stays 8. The popped majID is the oldest.
- Wrap-around: 20 cycles of continuous push and pop with majID 0..19 -> dispatch sees 0..19 in order, count_o constant at 1 after the first cycle.
- With DECODE_QUEUE_FLUSH_EN: 5 entries queued, flush_i = 1 together with enable_i = 1 -> count_o = 0, valid_o = 0 next cycle. A subsequent push appears as head with valid_o = 1.
